// File: rtl/sort_fifo_ctl.sv
// Merge-sort run buffer: synchronous FIFO with occupancy flags, sticky errors, flush and an
// always-visible head word (dcmp) for the merge comparator.
module sort_fifo_ctl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_DEPTH = 4,
  parameter int unsigned AF_LEVEL   = 2**LOG2_DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter bit          REG_OUT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] dcmp,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FullCnt = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   AfCnt   = (LOG2_DEPTH+1)'(AF_LEVEL);
  localparam logic [LOG2_DEPTH:0]   AeCnt   = (LOG2_DEPTH+1)'(AE_LEVEL);
  localparam logic [LOG2_DEPTH:0]   CntOne  = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PtrOne  = LOG2_DEPTH'(1);

  if (LOG2_DEPTH < 1 || LOG2_DEPTH > 16 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH)
  begin : g_bad_params
    $error("sort_fifo_ctl: illegal LOG2_DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [LOG2_DEPTH:0]   count_d, count_q;
  logic                  overflow_d, overflow_q, underflow_d, underflow_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  assign head   = mem_q[rd_ptr_q];
  // A pop frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CntOne;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CntOne;
      end
      if (wr_en && full && !rd_acc) overflow_d = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem_q[wr_ptr_q] <= din;
  end

  if (REG_OUT) begin : g_reg_out
    logic [DATA_WIDTH-1:0] dout_d, dout_q;

    always_comb begin
      dout_d = dout_q;
      if (flush) begin
        dout_d = '0;
      end else if (rd_acc) begin
        dout_d = head;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dout = dout_q;
  end else begin : g_comb_out
    assign dout = rd_acc ? head : '0;
  end

  assign dcmp         = head;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == FullCnt);
  assign almost_full  = (count_q >= AfCnt);
  assign almost_empty = (count_q <= AeCnt);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sort_fifo_ctl.sv
// Bench for sort_fifo_ctl: drives a combinational-output and a registered-output instance with
// shared directed stimulus and compares both against a queue-based model every cycle.
module tb_sort_fifo_ctl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] din = '0;

  logic [31:0] dout0, dcmp0, dout1, dcmp1;
  logic [4:0]  count0, count1;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic        full1, empty1, af1, ae1, ovf1, unf1;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Model state: plain queue of stored words plus sticky flags and the registered-output word.
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic [31:0] m_dreg = '0;
  bit          m_racc, m_wacc;

  sort_fifo_ctl #(.DATA_WIDTH(32), .LOG2_DEPTH(4), .REG_OUT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout0), .dcmp(dcmp0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sort_fifo_ctl #(.DATA_WIDTH(32), .LOG2_DEPTH(4), .REG_OUT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout1), .dcmp(dcmp1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dreg = '0;
    end else if (flush) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dreg = '0;
    end else begin
      m_racc = rd_en && (mq.size() > 0);
      m_wacc = wr_en && ((mq.size() < DEPTH) || m_racc);
      if (wr_en && mq.size() == DEPTH && !m_racc) m_ovf = 1'b1;
      if (rd_en && mq.size() == 0) m_unf = 1'b1;
      if (m_racc) m_dreg = mq.pop_front();
      if (m_wacc) mq.push_back(din);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  task automatic check_dut(input string tag, input logic [31:0] d_act, input logic [31:0] d_exp,
                           input logic [31:0] dcmp_act, input logic [4:0] cnt, input logic f,
                           input logic e, input logic a_f, input logic a_e, input logic ov,
                           input logic un);
    int n = mq.size();
    chk({tag, ".count"}, 32'(cnt), n);
    chk({tag, ".full"}, 32'(f), 32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(e), 32'(n == 0));
    chk({tag, ".almost_full"}, 32'(a_f), 32'(n >= DEPTH - 2));
    chk({tag, ".almost_empty"}, 32'(a_e), 32'(n <= 2));
    chk({tag, ".overflow"}, 32'(ov), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(un), 32'(m_unf));
    chk({tag, ".dout"}, d_act, d_exp);
    if (n > 0) chk({tag, ".dcmp"}, dcmp_act, mq[0]);
  endtask

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check_dut("cmp0", dout0, (reset && rd_en && mq.size() > 0) ? mq[0] : 32'h0, dcmp0,
                count0, full0, empty0, af0, ae0, ovf0, unf0);
      check_dut("cmp1", dout1, m_dreg, dcmp1, count1, full1, empty1, af1, ae1, ovf1, unf1);
    end
  end

  task automatic step(input bit we, input bit re, input bit fl, input logic [31:0] d);
    @(posedge clk);
    #1;
    wr_en = we;
    rd_en = re;
    flush = fl;
    din   = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #2 reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(count0), 32'h0);
    chk("rst_empty", 32'(empty0), 32'h1);
    chk("rst_almost_empty", 32'(ae0), 32'h1);
    chk("rst_full", 32'(full0), 32'h0);
    chk("rst_dout_reg", dout1, 32'h0);

    // Fill: almost_full must rise exactly when 14 words are held.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h10 + 32'(i));
      @(negedge clk);
      chk("fill_count", 32'(count0), 32'(i));
      chk("fill_almost_full", 32'(af0), 32'(i >= 14));
    end
    step(1'b1, 1'b0, 1'b0, 32'hDEAD);
    @(negedge clk);
    chk("full_flag", 32'(full0), 32'h1);
    chk("full_count", 32'(count0), 32'd16);
    idle();
    @(negedge clk);
    chk("overflow_set", 32'(ovf0), 32'h1);
    chk("overflow_count", 32'(count0), 32'd16);
    chk("overflow_head", dcmp0, 32'h10);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("drain_dout", dout0, 32'h10 + 32'(i));
    end
    idle();
    @(negedge clk);
    chk("drain_empty", 32'(empty0), 32'h1);
    chk("drain_count", 32'(count0), 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle();
    @(negedge clk);
    chk("flush_overflow", 32'(ovf0), 32'h0);
    chk("flush_empty", 32'(empty0), 32'h1);

    // Read+write while empty: write lands, read rejected.
    step(1'b1, 1'b1, 1'b0, 32'hA5);
    @(negedge clk);
    chk("empty_rw_dout", dout0, 32'h0);
    idle();
    @(negedge clk);
    chk("underflow_set", 32'(unf0), 32'h1);
    chk("empty_rw_count", 32'(count0), 32'h1);
    chk("empty_rw_dcmp", dcmp0, 32'hA5);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
    step(1'b1, 1'b1, 1'b0, 32'h55);
    @(negedge clk);
    chk("full_rw_pre_count", 32'(count0), 32'd16);
    chk("full_rw_dout", dout0, 32'hA5);
    idle();
    @(negedge clk);
    chk("full_rw_count", 32'(count0), 32'd16);
    chk("full_rw_no_overflow", 32'(ovf0), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("full_rw_drain", dout0, (i < 15) ? 32'h100 + 32'(i) : 32'h55);
    end
    idle();
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle();

    // Wrap-around through single write/read pairs.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
      step(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("wrap_dout", dout0, 32'h200 + 32'(i));
      chk("wrap_count_le1", 32'(count0 <= 5'd1), 32'h1);
    end
    idle();

    // Peek without popping.
    step(1'b1, 1'b0, 1'b0, 32'h7);
    step(1'b1, 1'b0, 1'b0, 32'h3);
    repeat (5) begin
      idle();
      @(negedge clk);
      chk("peek_dcmp", dcmp0, 32'h7);
      chk("peek_count", 32'(count0), 32'h2);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("peek_pop", dout0, 32'h7);
    idle();
    @(negedge clk);
    chk("peek_next", dcmp0, 32'h3);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle();

    // Registered output and asynchronous reset mid-burst.
    step(1'b1, 1'b0, 1'b0, 32'h42);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    chk("regout_load", dout1, 32'h42);
    repeat (3) idle();
    @(negedge clk);
    chk("regout_hold", dout1, 32'h42);
    step(1'b1, 1'b0, 1'b0, 32'h300);
    step(1'b1, 1'b0, 1'b0, 32'h301);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("areset_dout", dout1, 32'h0);
    chk("areset_empty", 32'(empty1), 32'h1);
    chk("areset_count", 32'(count1), 32'h0);
    wr_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h99);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_reset_dout0", dout0, 32'h99);
    idle();
    @(negedge clk);
    chk("post_reset_dout1", dout1, 32'h99);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle();
    @(negedge clk);
    chk("flush_dout_reg", dout1, 32'h0);
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
